// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: coin unit values, default change width
// and the change dispenser state encoding.
package vend_pkg;

    localparam int AMT_W_DEFAULT = 3;

    localparam int QUARTER_UNITS = 1;
    localparam int HALF_UNITS    = 2;

    typedef enum logic [2:0] {
        DS_IDLE  = 3'd0,
        DS_REQ   = 3'd1,
        DS_GAP   = 3'd2,
        DS_DONE  = 3'd3,
        DS_FAULT = 3'd4
    } disp_state_t;

endpackage

// File: rtl/dispense_timer.sv
// Hopper acknowledge watchdog: counts enabled cycles since the last clear and
// flags the cycle in which the TIMEOUT_CYC-th enabled cycle is reached.
module dispense_timer #(
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic CLK,
    input  logic RES,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge CLK) begin
        if (RES || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Fires on the last allowed cycle so the owner leaves REQ on the next edge.
    assign expired = enable && (count == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/change_dispenser.sv
// Coin-return engine: pays out a change amount as half-dollars first, then
// quarters, over a req/ack hopper handshake. Optional hopper watchdog and
// FAULT state are built only when DISPENSE_TIMEOUT_EN is defined.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W       = AMT_W_DEFAULT,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             change_valid,
    input  logic [AMT_W-1:0] change_amt,
    output logic             change_ready,
    output logic             coin_req,
    output logic             coin_half,
    input  logic             coin_ack,
    output logic             done,
    output logic [AMT_W-1:0] remaining,
    output logic             fault
);

    localparam logic [2:0] ST_IDLE  = 3'(DS_IDLE);
    localparam logic [2:0] ST_REQ   = 3'(DS_REQ);
    localparam logic [2:0] ST_GAP   = 3'(DS_GAP);
    localparam logic [2:0] ST_DONE  = 3'(DS_DONE);
`ifdef DISPENSE_TIMEOUT_EN
    localparam logic [2:0] ST_FAULT = 3'(DS_FAULT);
`endif

    localparam logic [AMT_W-1:0] HALF_AMT    = AMT_W'(HALF_UNITS);
    localparam logic [AMT_W-1:0] QUARTER_AMT = AMT_W'(QUARTER_UNITS);

    logic [2:0]       state;
    logic [AMT_W-1:0] rem_after_ack;
    logic             timeout_hit;

    // coin_half is only ever set when remaining >= 2, so this cannot underflow.
    assign rem_after_ack = remaining - (coin_half ? HALF_AMT : QUARTER_AMT);

`ifdef DISPENSE_TIMEOUT_EN
    dispense_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .CLK     (CLK),
        .RES     (RES),
        .clear   (state != ST_REQ),
        .enable  (state == ST_REQ),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RES) begin
            state     <= ST_IDLE;
            remaining <= '0;
            coin_half <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (change_valid) begin
                        remaining <= change_amt;
                        coin_half <= (change_amt >= HALF_AMT);
                        state     <= (change_amt == '0) ? ST_DONE : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (coin_ack) begin
                        remaining <= rem_after_ack;
                        state     <= (rem_after_ack == '0) ? ST_DONE : ST_GAP;
                    end else if (timeout_hit) begin
`ifdef DISPENSE_TIMEOUT_EN
                        state <= ST_FAULT;
`endif
                    end
                end
                ST_GAP: begin
                    // Coin type is chosen here so it is stable for the whole REQ.
                    coin_half <= (remaining >= HALF_AMT);
                    state     <= ST_REQ;
                end
                ST_DONE: state <= ST_IDLE;
`ifdef DISPENSE_TIMEOUT_EN
                ST_FAULT: state <= ST_FAULT;
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign change_ready = (state == ST_IDLE);
    assign coin_req     = (state == ST_REQ);
    assign done         = (state == ST_DONE);
`ifdef DISPENSE_TIMEOUT_EN
    assign fault        = (state == ST_FAULT);
`else
    assign fault        = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized self-checking bench for change_dispenser; expected coin sequences,
// balances and timing come from the greedy half-then-quarter payout rule.
module tb_change_dispenser;

    localparam int AMT_W = 3;
    localparam int TOUT  = 8;

    logic             CLK = 1'b0;
    logic             RES = 1'b1;
    logic             change_valid = 1'b0;
    logic [AMT_W-1:0] change_amt = '0;
    logic             change_ready;
    logic             coin_req;
    logic             coin_half;
    logic             coin_ack = 1'b0;
    logic             done;
    logic [AMT_W-1:0] remaining;
    logic             fault;

    int checks = 0;
    int errors = 0;

    change_dispenser #(
        .AMT_W       (AMT_W),
        .TIMEOUT_CYC (TOUT)
    ) dut (
        .CLK          (CLK),
        .RES          (RES),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .change_ready (change_ready),
        .coin_req     (coin_req),
        .coin_half    (coin_half),
        .coin_ack     (coin_ack),
        .done         (done),
        .remaining    (remaining),
        .fault        (fault)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (change_ready !== 1'b1 || coin_req !== 1'b0 || done !== 1'b0 ||
            remaining !== '0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL %s: ready=%b req=%b done=%b rem=%0d fault=%b, required ready=1 req=0 done=0 rem=0 fault=0",
                     name, change_ready, coin_req, done, remaining, fault);
        end
    endtask

    task automatic test_reset();
        RES = 1'b1;
        step();
        step();
        RES = 1'b0;
        check_idle("reset_state");
        checks++;
        if (coin_half !== 1'b0) begin
            errors++;
            $display("FAIL reset_coin_half: got %b, required 0", coin_half);
        end
    endtask

    // Accepts amt, answers each coin request after a delay in [dmin,dmax]
    // and checks coin order, balance, stability, done timing and return to IDLE.
    task automatic run_payout(input string name, input int amt, input int dmin,
                              input int dmax, input bit stray);
        int  exp_q[$];
        int  got_q[$];
        int  rem      = amt;
        int  done_cyc = -1;
        int  done_cnt = 0;
        int  waitc    = 0;
        int  delay;
        bit  held_half = 1'b0;
        bit  unstable  = 1'b0;
        bit  rem_bad   = 1'b0;
        int  cyc;

        for (int i = 0; i < amt / 2; i++) exp_q.push_back(1);
        if (amt % 2 == 1) exp_q.push_back(0);

        checks++;
        if (change_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_before: got %b, required 1", name, change_ready);
        end

        change_amt   = AMT_W'(amt);
        change_valid = 1'b1;
        step();
        change_valid = 1'b0;
        delay = $urandom_range(dmax, dmin);

        for (cyc = 1; cyc < 300 && done_cyc < 0; cyc++) begin
            if (remaining !== AMT_W'(rem) && !rem_bad) begin
                rem_bad = 1'b1;
                checks++;
                errors++;
                $display("FAIL %s_remaining: cycle %0d got %0d, required %0d", name, cyc, remaining, rem);
            end
            if (coin_req === 1'b1) begin
                if (waitc == 0) held_half = coin_half;
                else if (coin_half !== held_half) unstable = 1'b1;
                if (waitc == delay) begin
                    coin_ack = 1'b1;
                    got_q.push_back(int'(coin_half));
                    if (got_q.size() <= exp_q.size())
                        rem -= (exp_q[got_q.size()-1] == 1) ? 2 : 1;
                    waitc = 0;
                    delay = $urandom_range(dmax, dmin);
                end else begin
                    waitc++;
                end
            end else if (stray) begin
                coin_ack = 1'($urandom_range(1, 0));
            end
            if (stray) begin
                change_valid = 1'($urandom_range(1, 0));
                change_amt   = AMT_W'($urandom_range(7, 0));
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
                done_cnt++;
            end
            step();
            coin_ack     = 1'b0;
            change_valid = 1'b0;
        end

        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL %s_done_timeout: no done within budget, required one pulse", name);
        end
        checks++;
        if (got_q != exp_q) begin
            errors++;
            $display("FAIL %s_coins: got %p, required %p", name, got_q, exp_q);
        end
        checks++;
        if (unstable) begin
            errors++;
            $display("FAIL %s_half_stable: coin_half changed while waiting for ack, required stable", name);
        end
        if (dmax == 0) begin
            checks++;
            if (done_cyc != ((exp_q.size() == 0) ? 1 : 2 * exp_q.size())) begin
                errors++;
                $display("FAIL %s_done_cycle: got %0d, required %0d", name, done_cyc,
                         (exp_q.size() == 0) ? 1 : 2 * exp_q.size());
            end
        end
        checks++;
        if (done !== 1'b0 || change_ready !== 1'b1 || remaining !== '0 || done_cnt != 1) begin
            errors++;
            $display("FAIL %s_after_done: done=%b ready=%b rem=%0d pulses=%0d, required 0 1 0 1",
                     name, done, change_ready, remaining, done_cnt);
        end
    endtask

    task automatic test_amt5();
        run_payout("amt5", 5, 0, 0, 1'b0);
    endtask

    task automatic test_amt0();
        run_payout("amt0", 0, 0, 0, 1'b0);
    endtask

    task automatic test_delayed_ack();
        run_payout("amt3_delay4", 3, 4, 4, 1'b0);
    endtask

    task automatic test_stray_inputs();
        coin_ack = 1'b1;
        step();
        coin_ack = 1'b0;
        check_idle("stray_ack_idle");
        run_payout("stray7", 7, 0, 2, 1'b1);
        run_payout("stray4", 4, 1, 3, 1'b1);
    endtask

    task automatic test_reset_mid_payout();
        change_amt   = 3'd6;
        change_valid = 1'b1;
        step();
        change_valid = 1'b0;
        coin_ack = 1'b1;
        step();
        coin_ack = 1'b0;
        step();
        checks++;
        if (coin_req !== 1'b1 || remaining !== 3'd4) begin
            errors++;
            $display("FAIL rst_mid_setup: req=%b rem=%0d, required req=1 rem=4", coin_req, remaining);
        end
        RES      = 1'b1;
        coin_ack = 1'b1;
        step();
        RES      = 1'b0;
        coin_ack = 1'b0;
        check_idle("rst_mid_payout");
        run_payout("after_rst_amt1", 1, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            int amt  = $urandom_range(7, 0);
            int dmax = $urandom_range(3, 0);
            run_payout("rand", amt, 0, dmax, 1'($urandom_range(1, 0)));
        end
    endtask

    task automatic test_back_to_back();
        run_payout("b2b_a", 2, 0, 0, 1'b0);
        run_payout("b2b_b", 1, 0, 0, 1'b0);
        run_payout("b2b_c", 7, 0, 0, 1'b0);
    endtask

`ifdef DISPENSE_TIMEOUT_EN
    task automatic test_timeout();
        int req_cycles = 0;
        change_amt   = 3'd2;
        change_valid = 1'b1;
        step();
        change_valid = 1'b0;
        for (int i = 0; i < 20 && coin_req === 1'b1; i++) begin
            req_cycles++;
            step();
        end
        checks++;
        if (req_cycles != TOUT || fault !== 1'b1 || coin_req !== 1'b0 || change_ready !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fault: req_cycles=%0d fault=%b req=%b ready=%b, required %0d 1 0 0",
                     req_cycles, fault, coin_req, change_ready, TOUT);
        end
        for (int i = 0; i < 5; i++) begin
            coin_ack     = 1'($urandom_range(1, 0));
            change_valid = 1'($urandom_range(1, 0));
            step();
        end
        coin_ack     = 1'b0;
        change_valid = 1'b0;
        checks++;
        if (fault !== 1'b1 || remaining !== 3'd2 || coin_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: fault=%b rem=%0d req=%b, required 1 2 0", fault, remaining, coin_req);
        end
        RES = 1'b1;
        step();
        RES = 1'b0;
        check_idle("timeout_cleared");
    endtask
`endif

    initial begin
        test_reset();
        test_amt5();
        test_amt0();
        test_delayed_ack();
        test_stray_inputs();
        test_reset_mid_payout();
        test_back_to_back();
        test_random();
`ifdef DISPENSE_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
